// File: rtl/safety_island_pkg.sv
// Shared types and constants for the safety-island memory arbiter.
package safety_island_pkg;

  localparam logic [31:0] ArbTimeoutErrVal = 32'hBADCAB1E;

  typedef enum logic {
    ArbPortInstr  = 1'b0,
    ArbPortShadow = 1'b1
  } arb_port_e;

endpackage

// File: rtl/fifo_v3.sv
// Minimal fifo_v3: synchronous FIFO with combinational head read, drops push-on-full and pop-on-empty.
module fifo_v3 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AddrW-1:0] LastPtr   = AddrW'(DEPTH - 1);
  localparam logic [AddrW-1:0] PtrOne    = AddrW'(1);
  localparam logic [AddrW:0]   FullCount = (AddrW + 1)'(DEPTH);
  localparam logic [AddrW:0]   CountOne  = (AddrW + 1)'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AddrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AddrW:0]        count_q, count_d;
  logic                  do_push, do_pop;

  assign full_o  = (count_q == FullCount);
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrOne;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrOne;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CountOne;
      2'b01:   count_d = count_q - CountOne;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only entries below count_q are ever observed.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/safety_mem_arbiter.sv
// Two-port round-robin arbiter onto one memory port with in-order response routing.
// Optional response timeout enabled by defining SAFETY_MEM_ARB_TIMEOUT_EN.
module safety_mem_arbiter
  import safety_island_pkg::*;
#(
  parameter int unsigned NumOutstanding = 2,
  parameter int unsigned TimeoutCycles  = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        p0_req_i,
  output logic        p0_gnt_o,
  input  logic        p0_we_i,
  input  logic [3:0]  p0_be_i,
  input  logic [31:0] p0_addr_i,
  input  logic [31:0] p0_wdata_i,
  output logic        p0_rvalid_o,
  output logic [31:0] p0_rdata_o,
  output logic        p0_err_o,
  input  logic        p1_req_i,
  output logic        p1_gnt_o,
  input  logic        p1_we_i,
  input  logic [3:0]  p1_be_i,
  input  logic [31:0] p1_addr_i,
  input  logic [31:0] p1_wdata_i,
  output logic        p1_rvalid_o,
  output logic [31:0] p1_rdata_o,
  output logic        p1_err_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic        unexpected_rsp_o,
  output logic        timeout_o
);

  arb_port_e   winner, head_port;
  arb_port_e   rr_q, rr_d, lock_idx_q, lock_idx_d;
  logic        lock_q, lock_d;
  logic        unexpected_q, unexpected_d;
  logic        winner_req, handshake;
  logic        fifo_full, fifo_empty;
  logic [0:0]  fifo_head;
  logic        real_rsp, rsp_valid, timeout_fire;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  // A requester that has presented mem_req_o keeps the port until it is granted.
  always_comb begin
    if (lock_q)                     winner = lock_idx_q;
    else if (p0_req_i && p1_req_i)  winner = rr_q;
    else if (p1_req_i)              winner = ArbPortShadow;
    else                            winner = ArbPortInstr;
  end

  always_comb begin
    winner_req  = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (rst_ni) begin
      if (winner == ArbPortShadow) begin
        winner_req  = p1_req_i;
        mem_we_o    = p1_we_i;
        mem_be_o    = p1_be_i;
        mem_addr_o  = p1_addr_i;
        mem_wdata_o = p1_wdata_i;
      end else begin
        winner_req  = p0_req_i;
        mem_we_o    = p0_we_i;
        mem_be_o    = p0_be_i;
        mem_addr_o  = p0_addr_i;
        mem_wdata_o = p0_wdata_i;
      end
    end
  end

  assign mem_req_o = winner_req & ~fifo_full;
  assign handshake = mem_req_o & mem_gnt_i;
  assign p0_gnt_o  = handshake & (winner == ArbPortInstr);
  assign p1_gnt_o  = handshake & (winner == ArbPortShadow);

  fifo_v3 #(
    .DATA_WIDTH (1),
    .DEPTH      (NumOutstanding)
  ) i_route_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (handshake),
    .data_i  (1'(winner)),
    .pop_i   (rsp_valid),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_port = arb_port_e'(fifo_head);
  assign real_rsp  = rst_ni & mem_rvalid_i & ~fifo_empty;
  assign rsp_valid = real_rsp | timeout_fire;

`ifdef SAFETY_MEM_ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);
  logic [CntW-1:0] cnt_q, cnt_d;

  assign timeout_fire = rst_ni & ~fifo_empty & ~mem_rvalid_i & (cnt_q == CntLast);
  assign timeout_o    = timeout_fire;

  always_comb begin
    cnt_d = cnt_q;
    if (rsp_valid)                       cnt_d = '0;
    else if (!fifo_empty && !mem_rvalid_i) cnt_d = cnt_q + CntW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  assign timeout_fire = 1'b0;
  assign timeout_o    = 1'b0;
`endif

  always_comb begin
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    if (rsp_valid) begin
      rsp_rdata = timeout_fire ? ArbTimeoutErrVal : mem_rdata_i;
      rsp_err   = timeout_fire | mem_err_i;
    end
  end

  assign p0_rvalid_o = rsp_valid & (head_port == ArbPortInstr);
  assign p1_rvalid_o = rsp_valid & (head_port == ArbPortShadow);
  assign p0_rdata_o  = p0_rvalid_o ? rsp_rdata : '0;
  assign p1_rdata_o  = p1_rvalid_o ? rsp_rdata : '0;
  assign p0_err_o    = p0_rvalid_o & rsp_err;
  assign p1_err_o    = p1_rvalid_o & rsp_err;

  always_comb begin
    rr_d         = rr_q;
    lock_d       = lock_q;
    lock_idx_d   = lock_idx_q;
    unexpected_d = unexpected_q | (mem_rvalid_i & fifo_empty);
    if (handshake) begin
      rr_d   = (winner == ArbPortInstr) ? ArbPortShadow : ArbPortInstr;
      lock_d = 1'b0;
    end else if (mem_req_o) begin
      lock_d     = 1'b1;
      lock_idx_d = winner;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q         <= ArbPortInstr;
      lock_q       <= 1'b0;
      lock_idx_q   <= ArbPortInstr;
      unexpected_q <= 1'b0;
    end else begin
      rr_q         <= rr_d;
      lock_q       <= lock_d;
      lock_idx_q   <= lock_idx_d;
      unexpected_q <= unexpected_d;
    end
  end

  assign unexpected_rsp_o = unexpected_q;

endmodule

// File: tb/tb_safety_mem_arbiter.sv
// Self-checking bench for safety_mem_arbiter: directed scenarios plus a randomized run against a queue model.
module tb_safety_mem_arbiter;

  localparam int NOUT = 2;
  localparam int TCYC = 16;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [1:0]  req, we, gnt, rvalid, err;
  logic [3:0]  be [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        mem_req, mem_gnt, mem_we, mem_rvalid, mem_err;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        unexp, tmo;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  safety_mem_arbiter #(
    .NumOutstanding (NOUT),
    .TimeoutCycles  (TCYC)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .p0_req_i         (req[0]),
    .p0_gnt_o         (gnt[0]),
    .p0_we_i          (we[0]),
    .p0_be_i          (be[0]),
    .p0_addr_i        (addr[0]),
    .p0_wdata_i       (wdata[0]),
    .p0_rvalid_o      (rvalid[0]),
    .p0_rdata_o       (rdata[0]),
    .p0_err_o         (err[0]),
    .p1_req_i         (req[1]),
    .p1_gnt_o         (gnt[1]),
    .p1_we_i          (we[1]),
    .p1_be_i          (be[1]),
    .p1_addr_i        (addr[1]),
    .p1_wdata_i       (wdata[1]),
    .p1_rvalid_o      (rvalid[1]),
    .p1_rdata_o       (rdata[1]),
    .p1_err_o         (err[1]),
    .mem_req_o        (mem_req),
    .mem_gnt_i        (mem_gnt),
    .mem_we_o         (mem_we),
    .mem_be_o         (mem_be),
    .mem_addr_o       (mem_addr),
    .mem_wdata_o      (mem_wdata),
    .mem_rvalid_i     (mem_rvalid),
    .mem_rdata_i      (mem_rdata),
    .mem_err_i        (mem_err),
    .unexpected_rsp_o (unexp),
    .timeout_o        (tmo)
  );

  typedef struct {
    logic [1:0]  rq;
    logic        rv;
    logic [31:0] rd;
    logic        er;
    logic        mreq;
    logic [1:0]  g;
    logic [1:0]  rvv;
    logic [1:0]  ev;
  } row_t;

  row_t ob_tbl [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req = 2'b00; we = 2'b00;
    be[0] = 4'h0; be[1] = 4'h0;
    addr[0] = 32'h0; addr[1] = 32'h0;
    wdata[0] = 32'h0; wdata[1] = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; mem_err = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 1'b0;
    req = 2'b11; addr[0] = 32'h1111_0000; addr[1] = 32'h2222_0000;
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    #2;
    vectors++;
    if ({mem_req, gnt, rvalid, unexp, tmo} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_ctl got=%b exp=0000000", {mem_req, gnt, rvalid, unexp, tmo});
    end
    tick();
    @(negedge clk);
    vectors++;
    if ({mem_addr, rdata[0], rdata[1], mem_we, mem_be} !== 101'b0) begin
      miscompares++;
      $display("FAIL reset_data addr=%h rd0=%h rd1=%h exp all zero", mem_addr, rdata[0], rdata[1]);
    end
    tick();
    idle_inputs();
    rst_ni = 1'b1;
    @(negedge clk);
    vectors++;
    if ({mem_req, unexp, tmo} !== 3'b0) begin
      miscompares++;
      $display("FAIL reset_release got=%b exp=000", {mem_req, unexp, tmo});
    end
    tick();
    $display("reset: outputs idle");
  endtask

  task automatic test_round_robin();
    int pend[$];
    int p;
    do_reset();
    addr[0] = 32'hA000_0000; addr[1] = 32'hB000_0000;
    req = 2'b11; mem_gnt = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mem_rvalid = (pend.size() > 0);
      mem_rdata  = 32'h1000 + i;
      @(negedge clk);
      vectors++;
      if (gnt !== 2'(1 << (i % 2)) || mem_addr !== addr[i % 2]) begin
        miscompares++;
        $display("FAIL rr_grant i=%0d gnt=%b addr=%h exp gnt=%b addr=%h",
                 i, gnt, mem_addr, 2'(1 << (i % 2)), addr[i % 2]);
      end
      if (pend.size() > 0) begin
        p = pend.pop_front();
        vectors++;
        if (rvalid !== 2'(1 << p) || rdata[p] !== mem_rdata) begin
          miscompares++;
          $display("FAIL rr_route i=%0d rvalid=%b rdata=%h exp rvalid=%b rdata=%h",
                   i, rvalid, rdata[p], 2'(1 << p), mem_rdata);
        end
      end
      pend.push_back(i % 2);
      $display("rr: grant p%0d addr=%h", i % 2, addr[i % 2]);
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_lock();
    do_reset();
    addr[0] = 32'h0000_1234; addr[1] = 32'h0000_5678;
    req = 2'b01; mem_gnt = 1'b1;
    @(negedge clk);
    vectors++;
    if (gnt !== 2'b01) begin
      miscompares++;
      $display("FAIL lock_pre gnt=%b exp=01", gnt);
    end
    tick();
    req = 2'b00; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h55;
    @(negedge clk);
    vectors++;
    if (rvalid !== 2'b01 || rdata[0] !== 32'h55) begin
      miscompares++;
      $display("FAIL lock_drain rvalid=%b rdata=%h exp 01/00000055", rvalid, rdata[0]);
    end
    tick();
    mem_rvalid = 1'b0;
    req = 2'b01;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) req = 2'b11;
      @(negedge clk);
      vectors++;
      if ({mem_req, gnt} !== 3'b100 || mem_addr !== addr[0]) begin
        miscompares++;
        $display("FAIL lock_hold i=%0d req_gnt=%b addr=%h exp 100/%h", i, {mem_req, gnt}, mem_addr, addr[0]);
      end
      tick();
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    vectors++;
    if (gnt !== 2'b01 || mem_addr !== addr[0]) begin
      miscompares++;
      $display("FAIL lock_release gnt=%b addr=%h exp 01/%h", gnt, mem_addr, addr[0]);
    end
    $display("lock: grant p0 addr=%h after 3 withheld cycles", addr[0]);
    tick();
    req = 2'b10;
    @(negedge clk);
    vectors++;
    if (gnt !== 2'b10 || mem_addr !== addr[1]) begin
      miscompares++;
      $display("FAIL lock_next gnt=%b addr=%h exp 10/%h", gnt, mem_addr, addr[1]);
    end
    $display("lock: grant p1 addr=%h", addr[1]);
    tick();
    idle_inputs();
  endtask

  task automatic test_outstanding();
    logic [31:0] exp0, exp1;
    ob_tbl = '{
      '{2'b01, 1'b0, 32'h0,         1'b0, 1'b1, 2'b01, 2'b00, 2'b00},
      '{2'b10, 1'b0, 32'h0,         1'b0, 1'b1, 2'b10, 2'b00, 2'b00},
      '{2'b01, 1'b0, 32'h0,         1'b0, 1'b0, 2'b00, 2'b00, 2'b00},
      '{2'b01, 1'b0, 32'h0,         1'b0, 1'b0, 2'b00, 2'b00, 2'b00},
      '{2'b01, 1'b1, 32'hD1D1_0001, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00},
      '{2'b01, 1'b0, 32'h0,         1'b0, 1'b1, 2'b01, 2'b00, 2'b00},
      '{2'b00, 1'b1, 32'hD2D2_0002, 1'b1, 1'b0, 2'b00, 2'b10, 2'b10},
      '{2'b00, 1'b1, 32'hD3D3_0003, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00},
      '{2'b00, 1'b0, 32'h0,         1'b0, 1'b0, 2'b00, 2'b00, 2'b00}
    };
    do_reset();
    addr[0] = 32'h0000_0A00; addr[1] = 32'h0000_0B00;
    mem_gnt = 1'b1;
    for (int i = 0; i < 9; i++) begin
      req = ob_tbl[i].rq; mem_rvalid = ob_tbl[i].rv; mem_rdata = ob_tbl[i].rd; mem_err = ob_tbl[i].er;
      exp0 = ob_tbl[i].rvv[0] ? ob_tbl[i].rd : 32'h0;
      exp1 = ob_tbl[i].rvv[1] ? ob_tbl[i].rd : 32'h0;
      @(negedge clk);
      vectors++;
      if ({mem_req, gnt, rvalid, err, unexp} !== {ob_tbl[i].mreq, ob_tbl[i].g, ob_tbl[i].rvv, ob_tbl[i].ev, 1'b0}) begin
        miscompares++;
        $display("FAIL outst_ctl row=%0d got=%b exp=%b", i, {mem_req, gnt, rvalid, err, unexp},
                 {ob_tbl[i].mreq, ob_tbl[i].g, ob_tbl[i].rvv, ob_tbl[i].ev, 1'b0});
      end
      vectors++;
      if (rdata[0] !== exp0 || rdata[1] !== exp1) begin
        miscompares++;
        $display("FAIL outst_data row=%0d rd0=%h rd1=%h exp %h %h", i, rdata[0], rdata[1], exp0, exp1);
      end
      $display("outstanding: row %0d req=%b rvalid=%b", i, req, mem_rvalid);
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_unexpected();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    vectors++;
    if ({rvalid, unexp} !== 3'b000 || rdata[0] !== 32'h0 || rdata[1] !== 32'h0) begin
      miscompares++;
      $display("FAIL unexp_drop rvalid=%b unexp=%b rd0=%h rd1=%h exp all zero", rvalid, unexp, rdata[0], rdata[1]);
    end
    tick();
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (unexp !== 1'b1) begin
        miscompares++;
        $display("FAIL unexp_sticky i=%0d got=%b exp=1", i, unexp);
      end
      tick();
    end
    $display("unexpected: stray response flagged");
    do_reset();
    @(negedge clk);
    vectors++;
    if (unexp !== 1'b0) begin
      miscompares++;
      $display("FAIL unexp_clear got=%b exp=0", unexp);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    addr[0] = 32'h0000_C000; addr[1] = 32'h0000_D000;
    we = 2'b11; be[0] = 4'hF; be[1] = 4'h3; wdata[0] = 32'h1; wdata[1] = 32'h2;
    mem_gnt = 1'b1; req = 2'b01;
    tick();
    req = 2'b10;
    tick();
    req = 2'b11; mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777; mem_err = 1'b1;
    #1;
    rst_ni = 1'b0;
    #1;
    vectors++;
    if ({mem_req, gnt, rvalid, err, unexp, tmo, mem_we, mem_be} !== 15'b0 ||
        {mem_addr, mem_wdata, rdata[0], rdata[1]} !== 128'b0) begin
      miscompares++;
      $display("FAIL midreset_outputs ctl=%b addr=%h wdata=%h rd0=%h rd1=%h exp all zero",
               {mem_req, gnt, rvalid, err, unexp, tmo, mem_we, mem_be}, mem_addr, mem_wdata, rdata[0], rdata[1]);
    end
    tick();
    idle_inputs();
    rst_ni = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h8888_8888;
    @(negedge clk);
    vectors++;
    if (rvalid !== 2'b00) begin
      miscompares++;
      $display("FAIL midreset_drop rvalid=%b exp=00", rvalid);
    end
    tick();
    mem_rvalid = 1'b0;
    @(negedge clk);
    vectors++;
    if (unexp !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_unexp got=%b exp=1", unexp);
    end
    $display("reset_mid: outstanding discarded, late response flagged");
    tick();
  endtask

  task automatic test_timeout();
    int          seen_at = -1;
    int          tmo_pulses = 0;
    logic [1:0]  rv_at = 2'b00, err_at = 2'b00;
    logic [31:0] rd_at = 32'h0;
    logic        tmo_at = 1'b0;
    do_reset();
    addr[0] = 32'h0000_E000;
    req = 2'b01; mem_gnt = 1'b1;
    tick();
    idle_inputs();
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (tmo) tmo_pulses++;
      if (seen_at < 0 && rvalid !== 2'b00) begin
        seen_at = i; rv_at = rvalid; err_at = err; rd_at = rdata[0]; tmo_at = tmo;
      end
      tick();
    end
`ifdef SAFETY_MEM_ARB_TIMEOUT_EN
    vectors++;
    if (seen_at != TCYC || rv_at !== 2'b01 || err_at !== 2'b01 || rd_at !== 32'hBADCAB1E) begin
      miscompares++;
      $display("FAIL timeout_rsp cycle=%0d rvalid=%b err=%b rdata=%h exp cycle=%0d 01 01 badcab1e",
               seen_at, rv_at, err_at, rd_at, TCYC);
    end
    vectors++;
    if (tmo_at !== 1'b1 || tmo_pulses != 1) begin
      miscompares++;
      $display("FAIL timeout_pulse at_rsp=%b pulses=%0d exp 1/1", tmo_at, tmo_pulses);
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    vectors++;
    if (rvalid !== 2'b00) begin
      miscompares++;
      $display("FAIL timeout_late rvalid=%b exp=00", rvalid);
    end
    tick();
    mem_rvalid = 1'b0;
    @(negedge clk);
    vectors++;
    if (unexp !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_late_unexp got=%b exp=1", unexp);
    end
    $display("timeout: synthetic error response at cycle %0d", seen_at);
    tick();
`else
    vectors++;
    if (seen_at != -1 || tmo_pulses != 0) begin
      miscompares++;
      $display("FAIL no_timeout rsp_cycle=%0d pulses=%0d exp -1/0", seen_at, tmo_pulses);
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    vectors++;
    if (rvalid !== 2'b01 || rdata[0] !== 32'h1234_5678 || err !== 2'b00) begin
      miscompares++;
      $display("FAIL no_timeout_late rvalid=%b rdata=%h err=%b exp 01/12345678/00", rvalid, rdata[0], err);
    end
    $display("timeout: disabled, response delivered after long wait");
    tick();
`endif
    idle_inputs();
  endtask

  task automatic test_random();
    int          mq[$];
    int          held, prio, win, tcnt, ep;
    bit          ereq, unexp_m, fire, popped;
    logic [1:0]  exp_g, exp_rv, exp_e, granted;
    logic [31:0] exp_d;
    do_reset();
    held = -1; prio = 0; tcnt = 0; unexp_m = 1'b0; granted = 2'b00;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!req[p] || granted[p]) begin
          req[p]   = ($urandom_range(0, 99) < 60);
          we[p]    = 1'($urandom_range(0, 1));
          be[p]    = 4'($urandom);
          addr[p]  = $urandom;
          wdata[p] = $urandom;
        end
      end
      mem_gnt    = ($urandom_range(0, 99) < 70);
      mem_rvalid = (mq.size() > 0) ? ($urandom_range(0, 99) < 45) : ($urandom_range(0, 99) < 3);
      mem_rdata  = $urandom;
      mem_err    = ($urandom_range(0, 99) < 20);
      @(negedge clk);

      if (held >= 0)              win = held;
      else if (req[0] && req[1])  win = prio;
      else if (req[1])            win = 1;
      else                        win = 0;
      ereq = req[win] && (mq.size() < NOUT);
      exp_g = 2'b00;
      if (ereq && mem_gnt) exp_g[win] = 1'b1;
      fire = 1'b0;
`ifdef SAFETY_MEM_ARB_TIMEOUT_EN
      fire = (mq.size() > 0) && !mem_rvalid && (tcnt == TCYC - 1);
`endif
      exp_rv = 2'b00; exp_e = 2'b00; exp_d = 32'h0;
      popped = (mq.size() > 0) && (mem_rvalid || fire);
      if (popped) begin
        ep = mq[0];
        exp_rv[ep] = 1'b1;
        exp_e[ep]  = fire ? 1'b1 : mem_err;
        exp_d      = fire ? 32'hBADCAB1E : mem_rdata;
      end

      vectors++;
      if ({mem_req, gnt} !== {ereq, exp_g}) begin
        miscompares++;
        $display("FAIL rnd_grant cyc=%0d req_gnt=%b exp=%b", c, {mem_req, gnt}, {ereq, exp_g});
      end
      if (ereq) begin
        vectors++;
        if ({mem_we, mem_be, mem_addr, mem_wdata} !== {we[win], be[win], addr[win], wdata[win]}) begin
          miscompares++;
          $display("FAIL rnd_payload cyc=%0d addr=%h wdata=%h exp addr=%h wdata=%h",
                   c, mem_addr, mem_wdata, addr[win], wdata[win]);
        end
      end
      vectors++;
      if ({rvalid, err} !== {exp_rv, exp_e}) begin
        miscompares++;
        $display("FAIL rnd_rsp cyc=%0d rvalid_err=%b exp=%b", c, {rvalid, err}, {exp_rv, exp_e});
      end
      vectors++;
      if (rdata[0] !== (exp_rv[0] ? exp_d : 32'h0) || rdata[1] !== (exp_rv[1] ? exp_d : 32'h0)) begin
        miscompares++;
        $display("FAIL rnd_rdata cyc=%0d rd0=%h rd1=%h exp=%h on %b", c, rdata[0], rdata[1], exp_d, exp_rv);
      end
      vectors++;
      if ({unexp, tmo} !== {unexp_m, fire}) begin
        miscompares++;
        $display("FAIL rnd_status cyc=%0d unexp_tmo=%b exp=%b", c, {unexp, tmo}, {unexp_m, fire});
      end

      if (mem_rvalid && mq.size() == 0) unexp_m = 1'b1;
      if (popped) begin
        $display("rnd: cyc %0d response to p%0d data=%h", c, mq[0], exp_d);
        void'(mq.pop_front());
        tcnt = 0;
      end else if (mq.size() > 0 && !mem_rvalid) begin
        tcnt++;
      end
      if (ereq && mem_gnt) begin
        $display("rnd: cyc %0d grant p%0d addr=%h", c, win, addr[win]);
        mq.push_back(win);
        prio = 1 - win;
        held = -1;
      end else if (ereq) begin
        held = win;
      end
      granted = exp_g;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst_ni = 1'b0;
    idle_inputs();
    test_reset();
    test_round_robin();
    test_lock();
    test_outstanding();
    test_unexpected();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/safety_mem_arbiter.md
SAFETY_MEM_ARBITER -- requirements
Module: safety_mem_arbiter

Interface
REQ-001 SHALL have parameter NumOutstanding, default 2, meaning the maximum number of granted transactions awaiting a response (1..8).
REQ-002 SHALL have parameter TimeoutCycles, default 1024, meaning the response timeout in cycles; used only when SAFETY_MEM_ARB_TIMEOUT_EN is defined.
REQ-003 SHALL have clk_i  in  1  clock; one clock.
REQ-004 SHALL have rst_ni  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have, per requester p in {0,1} (p0=instr, p1=shadow): p_req_i in 1; p_gnt_o out 1; p_we_i in 1; p_be_i in 4; p_addr_i in 32; p_wdata_i in 32; p_rvalid_o out 1; p_rdata_o out 32; p_err_o out 1.
REQ-006 SHALL have a shared memory port: mem_req_o out 1; mem_gnt_i in 1; mem_we_o out 1; mem_be_o out 4; mem_addr_o out 32; mem_wdata_o out 32; mem_rvalid_i in 1; mem_rdata_i in 32; mem_err_i in 1.
REQ-007 SHALL have status outputs: unexpected_rsp_o out 1, sticky flag for an unexpected response; timeout_o out 1, one-cycle pulse on timeout.

Function
REQ-008 SHALL arbitrate between the two requesters round-robin; when only one requester is active, that requester wins; on a tie, the requester not granted most recently wins.
REQ-009 SHALL assert mem_req_o combinationally from the winner's req when the outstanding count is less than NumOutstanding, and SHALL drive mem_we/be/addr/wdata from the winner.
REQ-010 SHALL assert p_gnt_o = mem_gnt_i & mem_req_o & (winner==p); the loser's gnt SHALL be 0.
REQ-011 SHALL lock the winner from the first cycle mem_req_o is high without mem_gnt_i until the handshake completes, even if the other requester becomes active.
REQ-012 SHALL push the winner index into the routing FIFO on each mem handshake (mem_req_o & mem_gnt_i), and SHALL update the round-robin pointer in that same cycle.
REQ-013 SHALL, on mem_rvalid_i with the FIFO non-empty, pop the head and drive p_rvalid_o=1, p_rdata_o=mem_rdata_i, p_err_o=mem_err_i to the head's requester in the same cycle (zero latency); the other port's rvalid SHALL be 0.
REQ-014 SHALL hold mem_req_o low while the FIFO is full, including in a cycle in which a pop happens (no same-cycle push-on-full).
REQ-015 SHALL allow a push and a pop in the same cycle when the FIFO is not full; the count SHALL be unchanged.
REQ-016 SHALL drop a mem_rvalid_i that arrives with the FIFO empty: no p_rvalid_o, and unexpected_rsp_o set until reset.
REQ-017 SHALL drive p_rdata_o=0 and p_err_o=0 whenever p_rvalid_o=0.

Reset
REQ-018 SHALL, while rst_ni=0, reset the FIFO to empty, set the round-robin pointer so that p0 wins the first tie, clear the lock, the timeout counter, unexpected_rsp_o, and timeout_o, and hold mem_req_o, both gnt, and both rvalid at 0.
REQ-019 SHALL discard all outstanding transactions on reset mid-operation; responses after reset SHALL follow REQ-016.

Configuration
REQ-020 SHALL include, with SAFETY_MEM_ARB_TIMEOUT_EN defined, a counter that increments each cycle the FIFO is non-empty and mem_rvalid_i=0, and clears on any pop.
REQ-021 SHALL, when the counter reaches TimeoutCycles-1, pop the head and deliver a synthetic response (rvalid=1, err=1, rdata=32'hBADCAB1E), pulse timeout_o, and clear the counter; a late real response then follows REQ-016.
REQ-022 SHALL, without SAFETY_MEM_ARB_TIMEOUT_EN, contain no counter, tie timeout_o to 0, and wait for responses indefinitely.

Structure
REQ-023 SHALL place the constant ArbTimeoutErrVal (32'hBADCAB1E) and the requester index enum (ArbPortInstr=0, ArbPortShadow=1) in safety_island_pkg.
REQ-024 SHALL implement the routing FIFO with the common_cells fifo_v3 sub-module (DATA_WIDTH 1, DEPTH NumOutstanding).

Verification
REQ-025 SHALL cover: p0 and p1 requesting each cycle with mem_gnt_i=1 -> grants alternate p0,p1,p0,...; p0 first after reset.
REQ-026 SHALL cover: p0 request with gnt withheld 3 cycles while p1 rises -> mem_addr_o stays at p0 addr; p1 granted next.
REQ-027 SHALL cover: NumOutstanding=2, three grants without response -> third mem_req_o=0 until first rvalid; responses route p-order as granted.
REQ-028 SHALL cover: mem_rvalid_i with empty FIFO -> no p_rvalid_o; unexpected_rsp_o=1 until reset.
REQ-029 SHALL cover, with TIMEOUT_EN and TimeoutCycles=16: no response 16 cycles -> p_rvalid_o=1, err=1, rdata=32'hBADCAB1E, timeout_o pulse.
REQ-030 SHALL cover: rst_ni asserted with 2 outstanding -> all outputs 0; post-reset rvalid flagged unexpected.
